// File: rtl/regfile_write_arbiter_if.sv
// Writeback/MDU/register-file signal bundle around the write-port arbiter.
// The master side is the pipeline plus MDU environment. The slave side is the arbiter.
interface regfile_write_arbiter_if #(
  parameter int XLEN = 32
);
  logic            W_reg_write;
  logic [4:0]      W_rd_addr;
  logic [XLEN-1:0] W_rd;
  logic            mdu_valid;
  logic            mdu_ready;
  logic [4:0]      mdu_rd_addr;
  logic [XLEN-1:0] mdu_result;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            W_stall_req;
  logic            mdu_pending;

  modport master (
    output W_reg_write, W_rd_addr, W_rd, mdu_valid, mdu_rd_addr, mdu_result,
    input  mdu_ready, rf_we, rf_waddr, rf_wdata, W_stall_req, mdu_pending
  );

  modport slave (
    input  W_reg_write, W_rd_addr, W_rd, mdu_valid, mdu_rd_addr, mdu_result,
    output mdu_ready, rf_we, rf_waddr, rf_wdata, W_stall_req, mdu_pending
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between Writeback and a buffered MDU result stream.
// Starvation of the MDU is bounded by forcing a Writeback freeze slot.
module regfile_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      addr_q [FIFO_DEPTH];
  logic [XLEN-1:0] data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [ST_W-1:0]  starve_cnt;

  logic not_empty, not_full, pipe_use, force_slot, drain, push;

  assign not_empty  = (count != '0);
  assign not_full   = (count != CNT_W'(FIFO_DEPTH));
  assign pipe_use   = bus.W_reg_write && (bus.W_rd_addr != 5'd0);
  assign force_slot = not_empty && (starve_cnt == ST_W'(STARVE_LIMIT));
  assign push       = bus.mdu_valid && bus.mdu_ready;

  always_comb begin
    drain           = 1'b0;
    bus.rf_we       = 1'b0;
    bus.rf_waddr    = '0;
    bus.rf_wdata    = '0;
    bus.W_stall_req = 1'b0;
    bus.mdu_ready   = 1'b0;
    bus.mdu_pending = 1'b0;
    if (!rst) begin
      bus.mdu_ready   = not_full;
      bus.mdu_pending = not_empty;
      if (force_slot) begin
        bus.W_stall_req = 1'b1;
        drain           = 1'b1;
      end else if (pipe_use) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.W_rd_addr;
        bus.rf_wdata = bus.W_rd;
      end else if (not_empty) begin
        drain = 1'b1;
      end
      // An x0 head still takes the slot and is dropped without a write.
      if (drain) begin
        bus.rf_we    = (addr_q[rd_ptr] != 5'd0);
        bus.rf_waddr = addr_q[rd_ptr];
        bus.rf_wdata = data_q[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= bus.mdu_rd_addr;
        data_q[wr_ptr] <= bus.mdu_result;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (drain) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(drain);
      if (drain || !not_empty)
        starve_cnt <= '0;
      else if (pipe_use && (starve_cnt != ST_W'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + ST_W'(1);
    end
  end
endmodule
